// File: rtl/dom_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dom_pkg
// Shared LFSR constants, leap function and lane-width bound for DOM gadgets.
// Revision : 1.0
// ============================================================================
package dom_pkg;

  localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
  localparam logic [31:0] LFSR_ZERO_SUB = 32'h0000_0001;
  localparam int          LFSR_BITS     = 32;

  // seeded and out_valid are carried directly as state bits [0] and [1]
  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'b00,
    ST_EMPTY    = 2'b01,
    ST_FULL     = 2'b11
  } feed_state_e;

  // Three W-bit mask slices must fit in one LFSR state.
  function automatic logic w_legal(input int w);
    return (w >= 1) && (3 * w <= LFSR_BITS);
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  // Fixed 32-iteration bound keeps the unrolled chain static for synthesis.
  function automatic logic [31:0] lfsr_leap(input logic [31:0] state, input int steps);
    logic [31:0] s;
    s = state;
    for (int i = 0; i < LFSR_BITS; i++) begin
      if (i < steps) s = lfsr_step(s);
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_leap32.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_leap32
// Combinational STEPS-step leap of the 32-bit Galois LFSR.
// Revision : 1.0
// ============================================================================
module lfsr_leap32
  import dom_pkg::*;
#(
  parameter int STEPS = 32
) (
  input  logic [31:0] i_state,
  output logic [31:0] o_leap
);

  if ((STEPS < 1) || (STEPS > LFSR_BITS)) begin : g_steps_check
    $error("lfsr_leap32: STEPS out of range");
  end

  assign o_leap = lfsr_leap(i_state, STEPS);

endmodule
`default_nettype wire

// File: rtl/dom_share_feeder.sv
`default_nettype none
// ============================================================================
// Module   : dom_share_feeder
// Splits operands into two Boolean shares plus refresh bits for a DOM AND.
// Revision : 1.0
// ============================================================================
module dom_share_feeder
  import dom_pkg::*;
#(
  parameter int W     = 1,
  parameter int STEPS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         seed_valid,
  input  logic [31:0]  seed,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] a0,
  output logic [W-1:0] a1,
  output logic [W-1:0] b0,
  output logic [W-1:0] b1,
  output logic [W-1:0] z,
  output logic         seeded
);

  if (!w_legal(W)) begin : g_w_check
    $error("dom_share_feeder: W out of range");
  end

  feed_state_e  r_state;
  feed_state_e  w_state_next;
  logic [31:0]  r_lfsr;
  logic [31:0]  w_lfsr_leap;
  logic [W-1:0] r_a0, r_a1, r_b0, r_b1, r_z;
  logic [W-1:0] w_ma, w_mb, w_mz;
  logic         w_in_fire;
  logic         w_out_fire;

  assign seeded     = r_state[0];
  assign out_valid  = r_state[1];
  assign in_ready   = seeded && (!out_valid || out_ready);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  assign w_ma = r_lfsr[W-1:0];
  assign w_mb = r_lfsr[2*W-1:W];
  assign w_mz = r_lfsr[3*W-1:2*W];

  lfsr_leap32 #(
    .STEPS (STEPS)
  ) u_leap (
    .i_state (r_lfsr),
    .o_leap  (w_lfsr_leap)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_UNSEEDED: if (seed_valid) w_state_next = ST_EMPTY;
      ST_EMPTY:    if (w_in_fire) w_state_next = ST_FULL;
      ST_FULL:     if (!w_in_fire && w_out_fire) w_state_next = ST_EMPTY;
      default:     w_state_next = ST_UNSEEDED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_UNSEEDED;
    else     r_state <= w_state_next;
  end

  // A same-cycle seed overrides the leap; the transfer already used old masks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 32'h0;
    end else if (seed_valid) begin
      r_lfsr <= (seed == 32'h0) ? LFSR_ZERO_SUB : seed;
    end else if (w_in_fire) begin
      r_lfsr <= w_lfsr_leap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a0 <= '0;
      r_a1 <= '0;
      r_b0 <= '0;
      r_b1 <= '0;
      r_z  <= '0;
    end else if (w_in_fire) begin
      r_a0 <= a ^ w_ma;
      r_a1 <= w_ma;
      r_b0 <= b ^ w_mb;
      r_b1 <= w_mb;
      r_z  <= w_mz;
    end
  end

  assign a0 = r_a0;
  assign a1 = r_a1;
  assign b0 = r_b0;
  assign b1 = r_b1;
  assign z  = r_z;

endmodule
`default_nettype wire

// File: tb/tb_dom_share_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dom_share_feeder
// Scoreboard bench for dom_share_feeder at W=1 (directed) and W=8 (soak).
// Revision : 1.0
// ============================================================================
module tb_dom_share_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        d1_seed_valid, d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_seeded;
  logic [31:0] d1_seed;
  logic [0:0]  d1_a, d1_b, d1_a0, d1_a1, d1_b0, d1_b1, d1_z;

  logic        d8_seed_valid, d8_in_valid, d8_in_ready, d8_out_valid, d8_out_ready, d8_seeded;
  logic [31:0] d8_seed;
  logic [7:0]  d8_a, d8_b, d8_a0, d8_a1, d8_b0, d8_b1, d8_z;

  dom_share_feeder #(.W(1), .STEPS(32)) u_dut1 (
    .clk(clk), .rst(rst), .seed_valid(d1_seed_valid), .seed(d1_seed),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .a(d1_a), .b(d1_b),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready),
    .a0(d1_a0), .a1(d1_a1), .b0(d1_b0), .b1(d1_b1), .z(d1_z), .seeded(d1_seeded)
  );

  dom_share_feeder #(.W(8), .STEPS(32)) u_dut8 (
    .clk(clk), .rst(rst), .seed_valid(d8_seed_valid), .seed(d8_seed),
    .in_valid(d8_in_valid), .in_ready(d8_in_ready), .a(d8_a), .b(d8_b),
    .out_valid(d8_out_valid), .out_ready(d8_out_ready),
    .a0(d8_a0), .a1(d8_a1), .b0(d8_b0), .b1(d8_b1), .z(d8_z), .seeded(d8_seeded)
  );

  typedef struct packed {
    logic [7:0] a, b, ma, mb, mz;
  } bundle_t;

  bundle_t     q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  bit          cur = 1'b0;          // 0 selects the W=1 instance, 1 the W=8 one
  bit          g_fired;
  logic [31:0] m_lfsr;
  bit          m_seeded, m_ov;

  logic [7:0] o_a0, o_a1, o_b0, o_b1, o_z;
  logic       o_ov, o_ir, o_seeded;

  always_comb begin
    o_a0 = cur ? d8_a0 : {7'b0, d1_a0};
    o_a1 = cur ? d8_a1 : {7'b0, d1_a1};
    o_b0 = cur ? d8_b0 : {7'b0, d1_b0};
    o_b1 = cur ? d8_b1 : {7'b0, d1_b1};
    o_z  = cur ? d8_z  : {7'b0, d1_z};
    o_ov     = cur ? d8_out_valid : d1_out_valid;
    o_ir     = cur ? d8_in_ready  : d1_in_ready;
    o_seeded = cur ? d8_seeded    : d1_seeded;
  end

  function automatic logic [31:0] ref_leap(input logic [31:0] s, input int n);
    logic [31:0] t;
    t = s;
    for (int i = 0; i < n; i++) begin
      if (t[0]) t = {1'b0, t[31:1]} ^ 32'h8020_0003;
      else      t = {1'b0, t[31:1]};
    end
    return t;
  endfunction

  task automatic drive(input bit sv, input logic [31:0] sd, input bit iv,
                       input logic [7:0] ia, input logic [7:0] ib, input bit ordy);
    if (cur) begin
      d8_seed_valid = sv; d8_seed = sd; d8_in_valid = iv;
      d8_a = ia; d8_b = ib; d8_out_ready = ordy;
    end else begin
      d1_seed_valid = sv; d1_seed = sd; d1_in_valid = iv;
      d1_a = ia[0:0]; d1_b = ib[0:0]; d1_out_ready = ordy;
    end
  endtask

  // One clock: drive, check in_ready, advance the model, check registered outputs.
  task automatic step(input bit sv, input logic [31:0] sd, input bit iv,
                      input logic [7:0] ia_raw, input logic [7:0] ib_raw, input bit ordy);
    bit         exp_ir, in_fire, out_fire;
    bundle_t    bn;
    int         w;
    logic [7:0] mk, ia, ib;
    w  = cur ? 8 : 1;
    mk = cur ? 8'hFF : 8'h01;
    ia = ia_raw & mk;
    ib = ib_raw & mk;
    drive(sv, sd, iv, ia, ib, ordy);
    #1;
    exp_ir = m_seeded && (!m_ov || ordy);
    tests_run++;
    if (o_ir !== exp_ir) begin
      tests_failed++;
      $display("FAIL in_ready: got %b expected %b", o_ir, exp_ir);
    end
    out_fire = m_ov && ordy;
    in_fire  = iv && exp_ir;
    g_fired  = in_fire;
    if (out_fire && q.size() > 0) void'(q.pop_front());
    if (in_fire) begin
      bn.a  = ia;
      bn.b  = ib;
      bn.ma = 8'(m_lfsr) & mk;
      bn.mb = 8'(m_lfsr >> w) & mk;
      bn.mz = 8'(m_lfsr >> (2 * w)) & mk;
      q.push_back(bn);
      m_lfsr = ref_leap(m_lfsr, 32);
    end
    if (sv) begin
      m_lfsr   = (sd == 32'h0) ? 32'h1 : sd;
      m_seeded = 1'b1;
    end
    if (in_fire)       m_ov = 1'b1;
    else if (out_fire) m_ov = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (o_ov !== m_ov || o_seeded !== m_seeded) begin
      tests_failed++;
      $display("FAIL status: got ov=%b seeded=%b expected ov=%b seeded=%b", o_ov, o_seeded, m_ov, m_seeded);
    end
    if (m_ov) begin
      tests_run++;
      if (q.size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard: out_valid expected but no bundle queued");
      end else begin
        bn = q[0];
        if ({o_a0, o_a1, o_b0, o_b1, o_z} !== {bn.a ^ bn.ma, bn.ma, bn.b ^ bn.mb, bn.mb, bn.mz}) begin
          tests_failed++;
          $display("FAIL bundle: got a0=%h a1=%h b0=%h b1=%h z=%h expected a0=%h a1=%h b0=%h b1=%h z=%h",
                   o_a0, o_a1, o_b0, o_b1, o_z, bn.a ^ bn.ma, bn.ma, bn.b ^ bn.mb, bn.mb, bn.mz);
        end
        tests_run++;
        if ((o_a0 ^ o_a1) !== bn.a || (o_b0 ^ o_b1) !== bn.b) begin
          tests_failed++;
          $display("FAIL recombine: got a=%h b=%h expected a=%h b=%h", o_a0 ^ o_a1, o_b0 ^ o_b1, bn.a, bn.b);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cur = 1'b0; drive(1'b0, 32'h0, 1'b0, 8'h0, 8'h0, 1'b0);
    cur = 1'b1; drive(1'b0, 32'h0, 1'b0, 8'h0, 8'h0, 1'b0);
    cur = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_lfsr = 32'h0; m_seeded = 1'b0; m_ov = 1'b0; q.delete();
    tests_run++;
    if ({o_ov, o_ir, o_seeded} !== 3'b000 || {o_a0, o_a1, o_b0, o_b1, o_z} !== 40'h0) begin
      tests_failed++;
      $display("FAIL reset1: got ov=%b ir=%b seeded=%b shares=%h expected all zero",
               o_ov, o_ir, o_seeded, {o_a0, o_a1, o_b0, o_b1, o_z});
    end
    tests_run++;
    if ({d8_out_valid, d8_in_ready, d8_seeded} !== 3'b000 || {d8_a0, d8_a1, d8_b0, d8_b1, d8_z} !== 40'h0) begin
      tests_failed++;
      $display("FAIL reset8: got ov=%b ir=%b seeded=%b shares=%h expected all zero",
               d8_out_valid, d8_in_ready, d8_seeded, {d8_a0, d8_a1, d8_b0, d8_b1, d8_z});
    end
    rst = 1'b0;
  endtask

  task automatic test_gating();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b1, 8'h1, 8'h1, 1'b1);
      tests_run++;
      if (o_ov !== 1'b0 || o_ir !== 1'b0 || {o_a0, o_a1, o_b0, o_b1, o_z} !== 40'h0) begin
        tests_failed++;
        $display("FAIL gating: got ov=%b ir=%b shares=%h expected 0 0 0", o_ov, o_ir, {o_a0, o_a1, o_b0, o_b1, o_z});
      end
    end
  endtask

  task automatic test_single();
    step(1'b1, 32'h5, 1'b0, 8'h0, 8'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 8'h1, 8'h1, 1'b1);
    tests_run++;
    if ({o_a0[0], o_a1[0], o_b0[0], o_b1[0], o_z[0]} !== 5'b01101) begin
      tests_failed++;
      $display("FAIL single: got %b expected 01101", {o_a0[0], o_a1[0], o_b0[0], o_b1[0], o_z[0]});
    end
    tests_run++;
    if (u_dut1.r_lfsr !== ref_leap(32'h5, 32)) begin
      tests_failed++;
      $display("FAIL single_leap: got %h expected %h", u_dut1.r_lfsr, ref_leap(32'h5, 32));
    end
  endtask

  task automatic test_zero_seed();
    step(1'b1, 32'h0, 1'b0, 8'h0, 8'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 8'h1, 8'h0, 1'b1);
    tests_run++;
    if ({o_a0[0], o_a1[0], o_b0[0], o_b1[0], o_z[0]} !== 5'b01000) begin
      tests_failed++;
      $display("FAIL zero_seed: got %b expected 01000", {o_a0[0], o_a1[0], o_b0[0], o_b1[0], o_z[0]});
    end
  endtask

  task automatic test_backpressure();
    logic [39:0] held;
    logic [31:0] lfsr_hold;
    step(1'b0, 32'h0, 1'b1, 8'h0, 8'h1, 1'b1);
    held      = {o_a0, o_a1, o_b0, o_b1, o_z};
    lfsr_hold = u_dut1.r_lfsr;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
      tests_run++;
      if ({o_a0, o_a1, o_b0, o_b1, o_z} !== held || o_ir !== 1'b0 || u_dut1.r_lfsr !== lfsr_hold) begin
        tests_failed++;
        $display("FAIL backpressure: got shares=%h ir=%b lfsr=%h expected shares=%h ir=0 lfsr=%h",
                 {o_a0, o_a1, o_b0, o_b1, o_z}, o_ir, u_dut1.r_lfsr, held, lfsr_hold);
      end
    end
    step(1'b0, 32'h0, 1'b1, 8'h1, 8'h1, 1'b1);
    tests_run++;
    if (u_dut1.r_lfsr !== ref_leap(lfsr_hold, 32)) begin
      tests_failed++;
      $display("FAIL release_leap: got %h expected %h", u_dut1.r_lfsr, ref_leap(lfsr_hold, 32));
    end
  endtask

  task automatic test_seed_and_transfer();
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 8'h1, 8'h0, 1'b1);
    tests_run++;
    if (u_dut1.r_lfsr !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL seed_wins: got %h expected deadbeef", u_dut1.r_lfsr);
    end
    step(1'b0, 32'h0, 1'b1, 8'h0, 8'h1, 1'b1);
    tests_run++;
    if ({o_a0[0], o_a1[0], o_b0[0], o_b1[0], o_z[0]} !== 5'b11011) begin
      tests_failed++;
      $display("FAIL new_seed_masks: got %b expected 11011", {o_a0[0], o_a1[0], o_b0[0], o_b1[0], o_z[0]});
    end
  endtask

  task automatic test_seed_while_full();
    step(1'b0, 32'h0, 1'b1, 8'h1, 8'h1, 1'b0);
    step(1'b1, 32'h1234_5678, 1'b0, 8'h0, 8'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 8'h1, 8'h1, 1'b1);
    tests_run++;
    if ({o_a0[0], o_a1[0], o_b0[0], o_b1[0], o_z[0]} !== 5'b10100) begin
      tests_failed++;
      $display("FAIL seed_full: got %b expected 10100", {o_a0[0], o_a1[0], o_b0[0], o_b1[0], o_z[0]});
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b0, 32'h0, 1'b1, 8'h1, 8'h0, 1'b0);
    test_reset();
    step(1'b0, 32'h0, 1'b1, 8'h1, 8'h1, 1'b1);
    step(1'b1, 32'hA5A5_0F0F, 1'b0, 8'h0, 8'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 8'h1, 8'h1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 8'h0, 8'h0, 1'b1);
  endtask

  task automatic test_back_to_back_soak();
    int xfers = 0;
    int cyc   = 0;
    test_reset();
    cur = 1'b1;
    step(1'b1, $urandom, 1'b0, 8'h0, 8'h0, 1'b1);
    while (xfers < 10000 && cyc < 60000) begin
      step(($urandom_range(0, 999) == 0), $urandom, ($urandom_range(0, 3) != 0),
           8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
      if (g_fired) xfers++;
      cyc++;
    end
    tests_run++;
    if (xfers < 10000) begin
      tests_failed++;
      $display("FAIL soak_budget: got %0d transfers expected 10000", xfers);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
    step(1'b0, 32'h0, 1'b0, 8'h0, 8'h0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    cur = 1'b1; drive(1'b0, 32'h0, 1'b0, 8'h0, 8'h0, 1'b0);
    cur = 1'b0; drive(1'b0, 32'h0, 1'b0, 8'h0, 8'h0, 1'b0);
    m_lfsr = 32'h0; m_seeded = 1'b0; m_ov = 1'b0;
    test_reset();
    test_gating();
    test_single();
    test_zero_seed();
    test_backpressure();
    test_seed_and_transfer();
    test_seed_while_full();
    test_reset_midstream();
    test_back_to_back_soak();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
